i2c_slave_mpu: RTL and testbench

- Synthesizable I2C target (responder) that models the MPU6050 register interface.
- It is the far end of the I2C master inside mpu_top. It is instantiated in the mpu_top bench on the scl/sda lines, and can also stand in for the sensor in FPGA loopback.
- Implements 7-bit addressing, register-pointer writes, burst writes/reads with auto-increment, and repeated START. Sensor data registers are loaded from a parallel sample port.

---
 rtl/i2c_slave_mpu.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_slave_mpu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_mpu.sv
// I2C target modelling the MPU6050 register map (128 x 8, auto-increment,
// repeated START). Sensor registers 0x3B..0x48 load from a parallel sample port.
//
// Ports:
//   clk, rst_n        system clock (>= 10x SCL), async active-low reset
//   scl, sda_in       raw I2C clock / resolved SDA level (synchronised inside)
//   sda_oe            1 = pull SDA low, 0 = release
//   sample_load/data  14-byte sample; [111:104] -> 0x3B ... [7:0] -> 0x48
//   busy              addressed transaction in progress (START+match .. STOP)
//   wr_strobe/addr/data  one pulse per accepted write byte, addr/data held
`timescale 1ns/1ps
module i2c_slave_mpu #(
   parameter logic [6:0] DEV_ADDR = 7'h68,
   parameter logic [7:0] PWR_RST  = 8'h40
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         scl,
   input  logic         sda_in,
   output logic         sda_oe,
   input  logic         sample_load,
   input  logic [111:0] sample_data,
   output logic         busy,
   output logic         wr_strobe,
   output logic [6:0]   wr_addr,
   output logic [7:0]   wr_data
);

   localparam logic [6:0] RO_ADDR = 7'h75;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
   } state_t;

   state_t       r_state, w_nxt;
   logic [2:0]   r_scl_s, r_sda_s;
   logic [7:0]   r_regs [128];
   logic [7:0]   r_sh;
   logic [3:0]   r_cnt;
   logic [6:0]   r_ptr;
   logic         r_mack;
   logic         r_sda_oe, r_busy, r_wr_strobe;
   logic [6:0]   r_wr_addr;
   logic [7:0]   r_wr_data;
   logic [111:0] r_pend;
   logic         r_pend_v;

   logic w_scl, w_scl_p, w_sda, w_sda_p;
   logic w_rise, w_fall, w_start, w_stop;
   logic w_last, w_match;
   logic [7:0] w_byte, w_rd;

   // [1] is the synchronised level, [2] its previous value for edge detect
   assign w_scl   = r_scl_s[1];
   assign w_scl_p = r_scl_s[2];
   assign w_sda   = r_sda_s[1];
   assign w_sda_p = r_sda_s[2];
   assign w_rise  = w_scl & ~w_scl_p;
   assign w_fall  = ~w_scl & w_scl_p;
   assign w_start = w_scl & w_scl_p & w_sda_p & ~w_sda;
   assign w_stop  = w_scl & w_scl_p & ~w_sda_p & w_sda;
   assign w_byte  = {r_sh[6:0], w_sda};
   assign w_last  = (r_cnt == 4'd7);
   assign w_match = (w_byte[7:1] == DEV_ADDR);
   assign w_rd    = r_regs[r_ptr];

   assign sda_oe    = r_sda_oe;
   assign busy      = r_busy;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_s <= 3'b111;
         r_sda_s <= 3'b111;
      end else begin
         r_scl_s <= {r_scl_s[1:0], scl};
         r_sda_s <= {r_sda_s[1:0], sda_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      if (w_start) begin
         w_nxt = S_ADDR;
      end else if (w_stop) begin
         w_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_ADDR:
               if (w_rise && w_last) w_nxt = w_match ? S_ADDR_ACK : S_IDLE;
            S_ADDR_ACK:
               if (w_fall && r_sda_oe) w_nxt = r_sh[0] ? S_RDATA : S_REG;
            S_REG:
               if (w_rise && w_last) w_nxt = S_REG_ACK;
            S_REG_ACK, S_WDATA_ACK:
               if (w_fall && r_sda_oe) w_nxt = S_WDATA;
            S_WDATA:
               if (w_rise && w_last) w_nxt = S_WDATA_ACK;
            S_RDATA:
               if (w_fall && r_cnt == 4'd8) w_nxt = S_RACK;
            S_RACK:
               if (w_fall) w_nxt = r_mack ? S_IDLE : S_RDATA;
            default: w_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh        <= 8'h00;
         r_cnt       <= 4'd0;
         r_ptr       <= 7'd0;
         r_mack      <= 1'b1;
         r_sda_oe    <= 1'b0;
         r_busy      <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= 7'd0;
         r_wr_data   <= 8'h00;
         r_pend      <= '0;
         r_pend_v    <= 1'b0;
         for (int i = 0; i < 128; i++) r_regs[i] <= 8'h00;
         r_regs[7'h6B] <= PWR_RST;
         r_regs[RO_ADDR] <= {1'b0, DEV_ADDR};
      end else begin
         r_wr_strobe <= 1'b0;
         if (w_start) begin
            r_cnt    <= 4'd0;
            r_sda_oe <= 1'b0;
         end else if (w_stop) begin
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            unique case (r_state)
               S_ADDR, S_REG, S_WDATA: begin
                  if (w_rise) begin
                     r_sh  <= w_byte;
                     r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                     if (w_last && r_state == S_ADDR && w_match)
                        r_busy <= 1'b1;
                     if (w_last && r_state == S_REG)
                        r_ptr <= w_byte[6:0];
                     if (w_last && r_state == S_WDATA) begin
                        if (r_ptr != RO_ADDR) begin
                           r_regs[r_ptr] <= w_byte;
                           r_wr_strobe   <= 1'b1;
                           r_wr_addr     <= r_ptr;
                           r_wr_data     <= w_byte;
                        end
                        r_ptr <= r_ptr + 7'd1;
                     end
                  end
               end
               // first fall drives ACK, second fall ends it
               S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                  if (w_fall) begin
                     r_cnt <= 4'd0;
                     if (!r_sda_oe) begin
                        r_sda_oe <= 1'b1;
                     end else if (r_state == S_ADDR_ACK && r_sh[0]) begin
                        r_sh     <= w_rd;
                        r_sda_oe <= ~w_rd[7];
                     end else begin
                        r_sda_oe <= 1'b0;
                     end
                  end
               end
               S_RDATA: begin
                  if (w_rise) r_cnt <= r_cnt + 4'd1;
                  if (w_fall) begin
                     if (r_cnt == 4'd8) begin
                        r_sda_oe <= 1'b0;
                     end else begin
                        r_sda_oe <= ~r_sh[6];
                        r_sh     <= {r_sh[6:0], 1'b0};
                     end
                  end
               end
               S_RACK: begin
                  if (w_rise) begin
                     r_mack <= w_sda;
                     if (!w_sda) r_ptr <= r_ptr + 7'd1;
                  end
                  if (w_fall && !r_mack) begin
                     r_sh     <= w_rd;
                     r_sda_oe <= ~w_rd[7];
                     r_cnt    <= 4'd0;
                  end
               end
               default: ;
            endcase
         end
         // samples never land mid-transaction; a deferred one lands at STOP
         if (w_stop) begin
            if (r_pend_v)
               for (int k = 0; k < 14; k++)
                  r_regs[7'(59 + k)] <= r_pend[111 - 8*k -: 8];
            r_pend_v <= 1'b0;
         end
         if (sample_load) begin
            if (r_busy && !w_stop) begin
               r_pend   <= sample_data;
               r_pend_v <= 1'b1;
            end else begin
               for (int k = 0; k < 14; k++)
                  r_regs[7'(59 + k)] <= sample_data[111 - 8*k -: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_mpu.sv
// Bench for i2c_slave_mpu: bit-banged I2C master against a register-map model.
// Directed scenarios plus randomized burst write / read-back.
`timescale 1ns/1ps
module tb_i2c_slave_mpu;

   localparam int Q = 60;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         scl;
   logic         m_low;
   logic         sample_load;
   logic [111:0] sample_data;
   logic         sda_ln;
   logic         sda_oe, busy, wr_strobe;
   logic [6:0]   wr_addr;
   logic [7:0]   wr_data;

   assign sda_ln = ~(sda_oe | m_low);

   i2c_slave_mpu dut (
      .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_ln),
      .sda_oe(sda_oe), .sample_load(sample_load),
      .sample_data(sample_data), .busy(busy), .wr_strobe(wr_strobe),
      .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // reference model
   logic [7:0]   m_regs [128];
   logic [111:0] m_pend;
   bit           m_pend_v;
   bit           in_txn;
   logic [7:0]   wbuf [16];
   logic [111:0] mid_data;
   logic [31:0]  sq [$];

   function automatic void m_sample(input logic [111:0] d);
      for (int k = 0; k < 14; k++) m_regs[59 + k] = 8'(d >> (8 * (13 - k)));
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
      m_regs[8'h6B] = 8'h40;
      m_regs[8'h75] = 8'h68;
      m_pend_v = 0;
      in_txn = 0;
   endfunction

   function automatic void m_stop();
      if (m_pend_v) m_sample(m_pend);
      m_pend_v = 0;
      in_txn = 0;
   endfunction

   always @(negedge clk)
      if (wr_strobe) sq.push_back({17'd0, wr_addr, wr_data});

   task automatic load_sample(input logic [111:0] d);
      @(negedge clk);
      sample_data = d;
      sample_load = 1'b1;
      @(negedge clk);
      sample_load = 1'b0;
      if (in_txn) begin
         m_pend = d;
         m_pend_v = 1;
      end else begin
         m_sample(d);
      end
   endtask

   task automatic i2c_start();
      m_low = 1'b0; #Q;
      scl = 1'b1; #Q;
      m_low = 1'b1; #Q;
      scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      m_low = 1'b1; #Q;
      scl = 1'b1; #Q;
      m_low = 1'b0; #Q;
   endtask

   task automatic xbit(input logic b, output logic r);
      m_low = ~b; #Q;
      scl = 1'b1; #Q;
      r = sda_ln;
      scl = 1'b0; #Q;
   endtask

   task automatic tx(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) xbit(b[i], r);
      xbit(1'b1, ack);
   endtask

   task automatic rx(input logic nack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) xbit(1'b1, b[i]);
      xbit(nack, r);
   endtask

   task automatic wr_txn(input logic [6:0] ra, input int n);
      logic a, hb;
      logic [6:0] p;
      logic [31:0] eq [$];
      sq.delete();
      hb = 1'($urandom_range(0, 1));
      i2c_start();
      tx(8'hD0, a); chk("wr_aw", {31'd0, a}, 0);
      in_txn = 1;
      tx({hb, ra}, a); chk("wr_ptr", {31'd0, a}, 0);
      p = ra;
      for (int i = 0; i < n; i++) begin
         tx(wbuf[i], a); chk("wr_dack", {31'd0, a}, 0);
         if (p != 7'h75) begin
            m_regs[p] = wbuf[i];
            eq.push_back({17'd0, p, wbuf[i]});
         end
         p = p + 7'd1;
      end
      i2c_stop();
      m_stop();
      #Q;
      chk("wr_nstb", sq.size(), eq.size());
      for (int i = 0; i < eq.size(); i++)
         chk("wr_stb", (i < sq.size()) ? sq[i] : 32'hFFFF_FFFF, eq[i]);
      if (eq.size() > 0)
         chk("wr_hold", {17'd0, wr_addr, wr_data}, eq[eq.size() - 1]);
   endtask

   task automatic rd_txn(input logic [6:0] ra, input int n, input int mid);
      logic a, hb;
      logic [7:0] b;
      logic [6:0] p;
      hb = 1'($urandom_range(0, 1));
      i2c_start();
      tx(8'hD0, a); chk("rd_aw", {31'd0, a}, 0);
      in_txn = 1;
      tx({hb, ra}, a); chk("rd_ptr", {31'd0, a}, 0);
      i2c_start();
      tx(8'hD1, a); chk("rd_ar", {31'd0, a}, 0);
      p = ra;
      for (int i = 0; i < n; i++) begin
         if (i == mid) load_sample(mid_data);
         rx(i == n - 1, b);
         chk("rd_byte", {24'd0, b}, {24'd0, m_regs[p]});
         p = p + 7'd1;
      end
      chk("rd_rel", {31'd0, sda_oe}, 0);
      chk("rd_busy", {31'd0, busy}, 1);
      i2c_stop();
      m_stop();
      #Q;
      chk("rd_idle", {31'd0, busy}, 0);
   endtask

   initial begin
      logic a;
      logic [111:0] d1, d2;
      logic [6:0] ra;
      int n;
      rst_n = 1'b0; scl = 1'b1; m_low = 1'b0;
      sample_load = 1'b0; sample_data = '0;
      m_reset();
      for (int k = 0; k < 14; k++) begin
         d1[8*(13-k) +: 8] = 8'(k + 1);
         d2[8*(13-k) +: 8] = 8'(8'hF1 + k);
      end
      #21;
      chk("rst_oe", {31'd0, sda_oe}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_stb", {31'd0, wr_strobe}, 0);
      chk("rst_wa", {25'd0, wr_addr}, 0);
      chk("rst_wd", {24'd0, wr_data}, 0);
      #19 rst_n = 1'b1;
      #200;

      rd_txn(7'h6B, 1, -1);
      wbuf[0] = 8'h00; wr_txn(7'h6B, 1);
      rd_txn(7'h6B, 1, -1);
      rd_txn(7'h75, 1, -1);
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
      wr_txn(7'h7E, 3);
      rd_txn(7'h7E, 3, -1);
      wbuf[0] = 8'hAA; wr_txn(7'h75, 1);
      rd_txn(7'h75, 1, -1);

      load_sample(d1);
      #Q;
      mid_data = d2;
      rd_txn(7'h3B, 14, 5);
      rd_txn(7'h3B, 14, -1);

      repeat (6) begin
         ra = 7'($urandom_range(0, 127));
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
         wr_txn(ra, n);
         rd_txn(ra, n + 1, -1);
      end

      i2c_start();
      tx(8'hD2, a); chk("nack_addr", {31'd0, a}, 1);
      chk("nack_busy", {31'd0, busy}, 0);
      i2c_stop();
      #Q;
      chk("nack_oe", {31'd0, sda_oe}, 0);

      load_sample(d1);
      #Q;
      i2c_start();
      tx(8'hD0, a); chk("mr_aw", {31'd0, a}, 0);
      tx(8'h3B, a); chk("mr_ptr", {31'd0, a}, 0);
      i2c_start();
      tx(8'hD1, a); chk("mr_ar", {31'd0, a}, 0);
      chk("mr_drive", {31'd0, sda_oe}, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_oe", {31'd0, sda_oe}, 0);
      chk("mr_busy", {31'd0, busy}, 0);
      m_reset();
      m_low = 1'b0; scl = 1'b1;
      #50 rst_n = 1'b1;
      #Q;
      rd_txn(7'h3B, 1, -1);
      rd_txn(7'h6B, 1, -1);
      rd_txn(7'h75, 1, -1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
